mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 Op  input  6  opcode field of the instruction register, IR[31:26].
REQ-005 Funct  input  6  function field, IR[5:0].
REQ-006 Zero  input  1  ALU zero flag for the current cycle.
REQ-007 PCWr  output  1  PC write enable.
REQ-008 IRWr  output  1  instruction register write enable.
REQ-009 RegWr  output  1  register file write enable.
REQ-010 MemWr  output  1  data memory write enable.
REQ-011 ALUOp  output  4  ALU operation code.
- Encodings: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, SLL=7, NOR=8, LUI=9, SRL=10.
REQ-012 ALUSrcA  output  2  ALU A source: 0=PC, 1=rs, 2=zero-extended shamt.
REQ-013 ALUSrcB  output  2  ALU B source: 0=rt, 1=constant 4, 2=extended imm, 3=sign-extended imm<<2.
REQ-014 EXTOp  output  1  immediate extension: 1=sign, 0=zero.
REQ-015 RegDst  output  2  destination register: 0=rt, 1=rd, 2=$31.
REQ-016 WDSel  output  2  write-back data: 0=ALUOut, 1=MDR, 2=PC.
REQ-017 NPCOp  output  2  next-PC source: 0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target, 3=rs.
REQ-018 State  output  3  current FSM state, for debug.

Function
REQ-019 Moore/Mealy FSM; states IF=0, ID=1, EXE=2, MEM=3, WB=4; codes 5-7 SHALL transition to IF with all write enables 0.
REQ-020 Outputs are combinational from State, Op, Funct and Zero; unlisted outputs are 0 in every state.
REQ-021 IF: IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, NPCOp=0; next state ID.
REQ-022 ID: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, EXTOp=1 (branch target computed into ALUOut).
- j (Op 0x02): PCWr=1, NPCOp=2; next state IF.
- jal (Op 0x03): PCWr=1, NPCOp=2, RegWr=1, RegDst=2, WDSel=2; next state IF.
- jr (Op 0, Funct 0x08): PCWr=1, NPCOp=3; next state IF.
- Unsupported opcode or R-type funct: no write enables asserted; next state IF.
- All other instructions: next state EXE.
REQ-023 EXE, R-type (ALUSrcA=1, ALUSrcB=0, except sll/srl ALUSrcA=2): funct to ALUOp mapping is addu 0x21=ADD, subu 0x23=SUB, and 0x24=AND, or 0x25=OR, nor 0x27=NOR, slt 0x2A=SLT, sltu 0x2B=SLTU, sll 0x00=SLL, srl 0x02=SRL; next state WB.
REQ-024 EXE, I-type (ALUSrcA=1, ALUSrcB=2): addi 0x08=ADD with EXTOp=1; slti 0x0A=SLT with EXTOp=1; andi 0x0C=AND with EXTOp=0; ori 0x0D=OR with EXTOp=0; lui 0x0F=LUI; next state WB.
REQ-025 EXE, lw 0x23 / sw 0x2B: ALUSrcA=1, ALUSrcB=2, EXTOp=1, ALUOp=ADD; next state MEM.
REQ-026 EXE, beq 0x04 / bne 0x05: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, NPCOp=1.
- PCWr=Zero for beq, PCWr=!Zero for bne.
- Next state IF.
REQ-027 MEM: sw asserts MemWr=1 for exactly one cycle, next state IF; lw next state WB with no write enables.
REQ-028 WB: RegWr=1; RegDst=1 for R-type, 0 otherwise; WDSel=1 for lw, 0 otherwise; next state IF.
REQ-029 Cycles per instruction, IF to IF:
- j, jal, jr, illegal: 2.
- beq, bne: 3.
- sw: 4.
- R-type and I-type ALU: 4.
- lw: 5.
REQ-030 Each write enable is asserted in at most one cycle per instruction, except IRWr and PCWr in IF.

Reset
REQ-031 rst=1 forces State=IF immediately, without waiting for a clock edge, including mid-instruction.
REQ-032 While rst=1: PCWr, IRWr, RegWr and MemWr SHALL be 0; the other outputs take their IF values.
REQ-033 On the first rising edge after rst falls, the controller executes IF.

Structure
REQ-034 The shared ctrl_encode_def.v header holds:
- ALU op codes;
- NPCOp, WDSel, RegDst and ALUSrc codes;
- state codes;
- opcode and funct constants.
REQ-035 One combinational sub-module, mc_decode, classifies Op/Funct into instruction-class flags and the EXE-state ALUOp; mc_ctrl holds the state register and output logic.

Verification
REQ-036 Reset: assert rst mid-clock → State=0 and all write enables 0 in the same cycle; release rst → IRWr=1 and PCWr=1 at the next edge.
REQ-037 addu (Op 0, Funct 0x21) → states IF,ID,EXE,WB; EXE shows ALUOp=1; WB shows RegWr=1, RegDst=1, WDSel=0.
REQ-038 lw (Op 0x23) → 5 cycles; MemWr=0 throughout; WB shows RegWr=1, RegDst=0, WDSel=1.
REQ-039 beq (Op 0x04): Zero=1 in EXE → PCWr=1, NPCOp=1; Zero=0 → PCWr=0; next state IF in both cases.
REQ-040 jal (Op 0x03) → in ID: PCWr=1, NPCOp=2, RegWr=1, RegDst=2, WDSel=2; then IF.
REQ-041 sw (Op 0x2B) with rst asserted during MEM → MemWr drops to 0 at once and State=0; Op 0x3F → IF,ID,IF with no write enables asserted in ID.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// ALU ops, mux selects, FSM state codes, opcode/funct constants.
package mc_ctrl_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_RS  = 2'd3;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] SA_PC    = 2'd0;
    localparam logic [1:0] SA_RS    = 2'd1;
    localparam logic [1:0] SA_SHAMT = 2'd2;

    localparam logic [1:0] SB_RT   = 2'd0;
    localparam logic [1:0] SB_FOUR = 2'd1;
    localparam logic [1:0] SB_IMM  = 2'd2;
    localparam logic [1:0] SB_BR   = 2'd3;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic rtype;
        logic shift;
        logic itype;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller bundle: instruction fields and ALU flag in,
// datapath enables and selects out.
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemWr;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       EXTOp;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic [1:0] NPCOp;
    logic [2:0] State;

    modport master (
        output Op, Funct, Zero,
        input  PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrcA, ALUSrcB,
        input  EXTOp, RegDst, WDSel, NPCOp, State
    );

    modport slave (
        input  Op, Funct, Zero,
        output PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrcA, ALUSrcB,
        output EXTOp, RegDst, WDSel, NPCOp, State
    );

endinterface

// File: rtl/mc_decode.sv
// Instruction classifier: Op/Funct to class flags plus the
// ALU op and extension mode used in the EXE state.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec,
    output logic [3:0] alu_op,
    output logic       ext_op
);

    always_comb begin
        dec    = '0;
        alu_op = ALU_NOP;
        ext_op = 1'b0;
        unique case (op)
            OP_R: begin
                unique case (funct)
                    F_ADDU: begin dec.rtype = 1'b1; alu_op = ALU_ADD;  end
                    F_SUBU: begin dec.rtype = 1'b1; alu_op = ALU_SUB;  end
                    F_AND:  begin dec.rtype = 1'b1; alu_op = ALU_AND;  end
                    F_OR:   begin dec.rtype = 1'b1; alu_op = ALU_OR;   end
                    F_NOR:  begin dec.rtype = 1'b1; alu_op = ALU_NOR;  end
                    F_SLT:  begin dec.rtype = 1'b1; alu_op = ALU_SLT;  end
                    F_SLTU: begin dec.rtype = 1'b1; alu_op = ALU_SLTU; end
                    F_SLL: begin
                        dec.rtype = 1'b1;
                        dec.shift = 1'b1;
                        alu_op    = ALU_SLL;
                    end
                    F_SRL: begin
                        dec.rtype = 1'b1;
                        dec.shift = 1'b1;
                        alu_op    = ALU_SRL;
                    end
                    F_JR:    dec.jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: begin dec.itype = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
            OP_SLTI: begin dec.itype = 1'b1; alu_op = ALU_SLT; ext_op = 1'b1; end
            OP_ANDI: begin dec.itype = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin dec.itype = 1'b1; alu_op = ALU_OR;  end
            OP_LUI:  begin dec.itype = 1'b1; alu_op = ALU_LUI; end
            OP_LW:   begin dec.lw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
            OP_SW:   begin dec.sw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
            OP_BEQ:  begin dec.beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:  begin dec.bne = 1'b1; alu_op = ALU_SUB; end
            OP_J:    dec.j   = 1'b1;
            OP_JAL:  dec.jal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: state register plus state-decoded
// datapath controls; reset forces IF and masks all write enables.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mc_ctrl_if.slave bus
);

    logic [2:0] state;
    logic [2:0] nstate;
    dec_t       dec;
    logic [3:0] exe_alu;
    logic       exe_ext;
    logic       legal;
    logic       pc_wr, ir_wr, reg_wr, mem_wr;
    logic [3:0] alu_op;
    logic [1:0] src_a, src_b, reg_dst, wd_sel, npc_op;
    logic       ext_op;

    mc_decode u_dec (
        .op     (bus.Op),
        .funct  (bus.Funct),
        .dec    (dec),
        .alu_op (exe_alu),
        .ext_op (exe_ext)
    );

    assign legal = |dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IF;
        else     state <= nstate;
    end

    always_comb begin
        nstate  = ST_IF;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        reg_wr  = 1'b0;
        mem_wr  = 1'b0;
        alu_op  = ALU_NOP;
        src_a   = SA_PC;
        src_b   = SB_RT;
        ext_op  = 1'b0;
        reg_dst = RD_RT;
        wd_sel  = WD_ALU;
        npc_op  = NPC_PC4;
        unique case (state)
            ST_IF: begin
                ir_wr  = 1'b1;
                pc_wr  = 1'b1;
                src_b  = SB_FOUR;
                alu_op = ALU_ADD;
                nstate = ST_ID;
            end
            ST_ID: begin
                src_b  = SB_BR;
                alu_op = ALU_ADD;
                ext_op = 1'b1;
                unique case (1'b1)
                    dec.j: begin
                        pc_wr  = 1'b1;
                        npc_op = NPC_JMP;
                    end
                    dec.jal: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_JMP;
                        reg_wr  = 1'b1;
                        reg_dst = RD_RA;
                        wd_sel  = WD_PC;
                    end
                    dec.jr: begin
                        pc_wr  = 1'b1;
                        npc_op = NPC_RS;
                    end
                    default: if (legal) nstate = ST_EXE;
                endcase
            end
            ST_EXE: begin
                src_a  = SA_RS;
                alu_op = exe_alu;
                ext_op = exe_ext;
                unique case (1'b1)
                    dec.rtype: begin
                        if (dec.shift) src_a = SA_SHAMT;
                        nstate = ST_WB;
                    end
                    dec.itype: begin
                        src_b  = SB_IMM;
                        nstate = ST_WB;
                    end
                    dec.lw, dec.sw: begin
                        src_b  = SB_IMM;
                        nstate = ST_MEM;
                    end
                    dec.beq, dec.bne: begin
                        npc_op = NPC_BR;
                        pc_wr  = dec.beq ? bus.Zero : !bus.Zero;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (dec.sw)      mem_wr = 1'b1;
                else if (dec.lw) nstate = ST_WB;
            end
            ST_WB: begin
                reg_wr  = 1'b1;
                reg_dst = dec.rtype ? RD_RD : RD_RT;
                wd_sel  = dec.lw ? WD_MEM : WD_ALU;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst itself so they drop before the flop settles
    assign bus.PCWr    = pc_wr & ~rst;
    assign bus.IRWr    = ir_wr & ~rst;
    assign bus.RegWr   = reg_wr & ~rst;
    assign bus.MemWr   = mem_wr & ~rst;
    assign bus.ALUOp   = alu_op;
    assign bus.ALUSrcA = src_a;
    assign bus.ALUSrcB = src_b;
    assign bus.EXTOp   = ext_op;
    assign bus.RegDst  = reg_dst;
    assign bus.WDSel   = wd_sel;
    assign bus.NPCOp   = npc_op;
    assign bus.State   = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed plus randomized instruction streams against a per-cycle
// reference model built from instruction classes and cycle counts.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       ext;
        logic [1:0] rd;
        logic [1:0] wd;
        logic [1:0] npc;
    } exp_t;

    localparam int C_ILL = 0;
    localparam int C_R   = 1;
    localparam int C_SH  = 2;
    localparam int C_I   = 3;
    localparam int C_LW  = 4;
    localparam int C_SW  = 5;
    localparam int C_BEQ = 6;
    localparam int C_BNE = 7;
    localparam int C_J   = 8;
    localparam int C_JAL = 9;
    localparam int C_JR  = 10;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] legal_tab [0:20] = '{
        {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25},
        {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B}, {6'h00, 6'h00},
        {6'h00, 6'h02}, {6'h00, 6'h08}, {6'h08, 6'h00}, {6'h0A, 6'h00},
        {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
        {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
        {6'h03, 6'h00}
    };

    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h21, 6'h23, 6'h24, 6'h25,
                6'h27, 6'h2A, 6'h2B: return C_R;
                6'h00, 6'h02:        return C_SH;
                6'h08:               return C_JR;
                default:             return C_ILL;
            endcase
        end
        case (op)
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return C_I;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h05:   return C_BNE;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int cycles(int c);
        if (c == C_J || c == C_JAL || c == C_JR || c == C_ILL) return 2;
        if (c == C_BEQ || c == C_BNE) return 3;
        if (c == C_LW) return 5;
        return 4;
    endfunction

    function automatic logic [3:0] exe_alu(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h21: return 4'd1;
                6'h23: return 4'd2;
                6'h24: return 4'd3;
                6'h25: return 4'd4;
                6'h27: return 4'd8;
                6'h2A: return 4'd5;
                6'h2B: return 4'd6;
                6'h00: return 4'd7;
                6'h02: return 4'd10;
                default: return 4'd0;
            endcase
        end
        case (op)
            6'h08, 6'h23, 6'h2B: return 4'd1;
            6'h0A: return 4'd5;
            6'h0C: return 4'd3;
            6'h0D: return 4'd4;
            6'h0F: return 4'd9;
            6'h04, 6'h05: return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = IF) of an instruction
    function automatic exp_t model(int k, logic [5:0] op, logic [5:0] fn,
                                   logic zero, logic in_rst);
        exp_t e;
        int c;
        e = '0;
        c = classify(op, fn);
        if (in_rst || k == 0) begin
            e.pcwr = !in_rst;
            e.irwr = !in_rst;
            e.sb   = 2'd1;
            e.alu  = 4'd1;
            return e;
        end
        if (k == 1) begin
            e.st  = 3'd1;
            e.sb  = 2'd3;
            e.alu = 4'd1;
            e.ext = 1'b1;
            if (c == C_J || c == C_JAL || c == C_JR) begin
                e.pcwr = 1'b1;
                e.npc  = (c == C_JR) ? 2'd3 : 2'd2;
            end
            if (c == C_JAL) begin
                e.regwr = 1'b1;
                e.rd    = 2'd2;
                e.wd    = 2'd2;
            end
            return e;
        end
        if (k == 2) begin
            e.st  = 3'd2;
            e.sa  = (c == C_SH) ? 2'd2 : 2'd1;
            e.alu = exe_alu(op, fn);
            e.sb  = (c == C_I || c == C_LW || c == C_SW) ? 2'd2 : 2'd0;
            e.ext = (c == C_LW || c == C_SW ||
                     (c == C_I && (op == 6'h08 || op == 6'h0A)));
            if (c == C_BEQ || c == C_BNE) begin
                e.npc  = 2'd1;
                e.pcwr = (c == C_BEQ) ? zero : !zero;
            end
            return e;
        end
        if (k == 3 && (c == C_LW || c == C_SW)) begin
            e.st    = 3'd3;
            e.memwr = (c == C_SW);
            return e;
        end
        e.st    = 3'd4;
        e.regwr = 1'b1;
        e.rd    = (c == C_R || c == C_SH) ? 2'd1 : 2'd0;
        e.wd    = (c == C_LW) ? 2'd1 : 2'd0;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t o;
        o.st    = bus.State;
        o.pcwr  = bus.PCWr;
        o.irwr  = bus.IRWr;
        o.regwr = bus.RegWr;
        o.memwr = bus.MemWr;
        o.alu   = bus.ALUOp;
        o.sa    = bus.ALUSrcA;
        o.sb    = bus.ALUSrcB;
        o.ext   = bus.EXTOp;
        o.rd    = bus.RegDst;
        o.wd    = bus.WDSel;
        o.npc   = bus.NPCOp;
        return o;
    endfunction

    task automatic check(string tag, exp_t e);
        exp_t o;
        o = sample();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // zmode < 0: random Zero each cycle; abort_k >= 0: reset in that cycle
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int zmode,
                             int abort_k, string tag);
        int n;
        n = cycles(classify(op, fn));
        for (int k = 0; k < n; k++) begin
            bus.Op    = op;
            bus.Funct = fn;
            bus.Zero  = (zmode < 0) ? 1'($urandom % 2) : 1'(zmode);
            #1;
            check($sformatf("%s.c%0d", tag, k),
                  model(k, op, fn, bus.Zero, 1'b0));
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1 check($sformatf("%s.rst", tag),
                         model(0, op, fn, bus.Zero, 1'b1));
                @(negedge clk);
                #1 check($sformatf("%s.rst_hold", tag),
                         model(0, op, fn, bus.Zero, 1'b1));
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [11:0] ent;
        rst       = 1'b1;
        bus.Op    = 6'h00;
        bus.Funct = 6'h00;
        bus.Zero  = 1'b0;
        @(negedge clk);
        #1 check("reset", model(0, 6'h00, 6'h00, 1'b0, 1'b1));
        rst = 1'b0;

        run_instr(6'h00, 6'h21, -1, -1, "addu");
        run_instr(6'h23, 6'h00, -1, -1, "lw");
        run_instr(6'h04, 6'h00, 1, -1, "beq_z1");
        run_instr(6'h04, 6'h00, 0, -1, "beq_z0");
        run_instr(6'h05, 6'h00, 1, -1, "bne_z1");
        run_instr(6'h03, 6'h00, -1, -1, "jal");
        run_instr(6'h2B, 6'h00, -1, 3, "sw_rst");
        run_instr(6'h3F, 6'h00, -1, -1, "illegal");
        run_instr(6'h00, 6'h08, -1, -1, "jr");
        run_instr(6'h00, 6'h02, -1, -1, "srl");
        run_instr(6'h0F, 6'h00, -1, -1, "lui");
        run_instr(6'h2B, 6'h00, -1, -1, "sw");

        for (int i = 0; i < 150; i++) begin
            if ($urandom % 4 != 0) begin
                ent = legal_tab[$urandom % 21];
                op  = ent[11:6];
                fn  = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, -1, -1, $sformatf("rnd%0d", i));
        end

        #1 check("final_if", model(0, 6'h00, 6'h00, 1'b0, 1'b0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
